ifetch: RTL and testbench

Instruction fetch stage of the pipelined MIPS core. It holds the program counter, drives the word address of the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for decode. It also handles stall, flush and redirects, including redirects that arrive during a stall, and enters a sticky fault state on a misaligned or out-of-range fetch.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/ifid_reg.sv | 21 ++
 rtl/ifetch.sv | 94 +++++++++
 tb/tb_ifetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } ifetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // IF/ID payload. valid=1 means instr/pcplus4 hold a real fetched
    // instruction; valid=0 marks a bubble and decode must ignore the payload.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: clear (bubble) beats enable, enable low holds.
module ifid_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  en,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '{instr: NOP, pcplus4: 32'h0, valid: 1'b0};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, pending-redirect register, BOOT/RUN/FAULT FSM
// and the IF/ID register feeding decode.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_AW    = 6,
    parameter int          IMEM_DEPTH = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_f,
    input  logic               flush_d,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_a,
    input  logic [31:0]        imem_rd,
    output logic [31:0]        instr_d,
    output logic [31:0]        pcplus4_d,
    output logic               valid_d,
    output logic [31:0]        pc_f,
    output logic               fetch_fault
);

    ifetch_state_t state;
    logic          pending;
    logic [31:0]   pending_pc;
    logic [31:0]   pcplus4_f;
    logic          run;
    logic          fault_fetch;
    logic          capture_fault;
    ifid_t         ifid_d;
    ifid_t         ifid_q;

    assign run           = (state == RUN);
    assign pcplus4_f     = pc_f + 32'd4;
    assign imem_a        = pc_f[IMEM_AW+1:2];
    assign fault_fetch   = (pc_f[1:0] != 2'b00) || (pc_f[31:2] >= 30'(IMEM_DEPTH));
    // A fault is only taken when IF/ID would actually capture the fetch.
    assign capture_fault = run && !stall_f && fault_fetch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc_f        <= RESET_PC;
            pending     <= 1'b0;
            pending_pc  <= 32'h0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (stall_f) begin
                        if (redirect) begin
                            pending    <= 1'b1;
                            pending_pc <= redirect_pc;
                        end
                    end else begin
                        pending <= 1'b0;
                        // PC stays on the faulting address so it can be inspected.
                        if (capture_fault) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end else if (redirect) begin
                            pc_f <= redirect_pc;
                        end else if (pending) begin
                            pc_f <= pending_pc;
                        end else begin
                            pc_f <= pcplus4_f;
                        end
                    end
                end
                FAULT:   pending <= 1'b0;
                default: state <= BOOT;
            endcase
        end
    end

    assign ifid_d = '{instr: imem_rd, pcplus4: pcplus4_f, valid: 1'b1};

    ifid_reg u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .clear (flush_d || !run || capture_fault),
        .en    (!stall_f),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign instr_d   = ifid_q.instr;
    assign pcplus4_d = ifid_q.pcplus4;
    assign valid_d   = ifid_q.valid;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: boot, sequential fetch, redirects, stall with
// pending redirect, flush, faults and reset during a pending redirect.
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        flush_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [31:0] pc_f;
    logic        fetch_fault;

    logic [31:0] imem [64];
    int          checks;
    int          errors;

    ifetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_AW    (6),
        .IMEM_DEPTH (40)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .flush_d     (flush_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .instr_d     (instr_d),
        .pcplus4_d   (pcplus4_d),
        .valid_d     (valid_d),
        .pc_f        (pc_f),
        .fetch_fault (fetch_fault)
    );

    assign imem_rd = imem[imem_a];

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 + 32'(i);
        imem[0] = 32'd11;
        imem[1] = 32'd22;
        imem[2] = 32'd33;
        imem[3] = 32'd44;

        reset = 1'b1; stall_f = 1'b0; flush_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        reset = 1'b0;
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_pcp4", pcplus4_d, 32'h0);
        chk("rst_valid", {31'b0, valid_d}, 32'd0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // BOOT edge: bubble, PC holds
        step();
        chk("boot_valid", {31'b0, valid_d}, 32'd0);
        chk("boot_pc", pc_f, 32'h0);

        step();
        chk("run0_instr", instr_d, 32'd11);
        chk("run0_pcp4", pcplus4_d, 32'd4);
        chk("run0_valid", {31'b0, valid_d}, 32'd1);
        step();
        chk("run1_instr", instr_d, 32'd22);
        chk("run1_pcp4", pcplus4_d, 32'd8);
        chk("run1_pc", pc_f, 32'h8);

        // redirect to 0x20 while fetching 0x8
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        chk("redir_pc", pc_f, 32'h20);
        chk("redir_instr", instr_d, 32'd33);
        chk("redir_pcp4", pcplus4_d, 32'd12);
        step();
        chk("redir_tgt_instr", instr_d, 32'hA000_0008);
        chk("redir_tgt_pcp4", pcplus4_d, 32'h24);
        chk("redir_tgt_valid", {31'b0, valid_d}, 32'd1);

        // stall 3 cycles, redirects in stall cycles 1 and 2
        stall_f = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        chk("stall1_pc", pc_f, 32'h24);
        chk("stall1_instr", instr_d, 32'hA000_0008);
        redirect_pc = 32'h44;
        step();
        chk("stall2_pc", pc_f, 32'h24);
        redirect = 1'b0;
        step();
        chk("stall3_pc", pc_f, 32'h24);
        chk("stall3_pcp4", pcplus4_d, 32'h24);
        stall_f = 1'b0;
        step();
        chk("release_pc", pc_f, 32'h44);
        chk("release_instr", instr_d, 32'hA000_0009);
        chk("imem_a", {26'b0, imem_a}, 32'd17);
        step();
        chk("pend_tgt_instr", instr_d, 32'hA000_0011);
        chk("pend_tgt_pcp4", pcplus4_d, 32'h48);

        // flush beats stall
        flush_d = 1'b1; stall_f = 1'b1;
        step();
        chk("flush_valid", {31'b0, valid_d}, 32'd0);
        chk("flush_instr", instr_d, 32'h0);
        chk("flush_pc", pc_f, 32'h48);
        flush_d = 1'b0; stall_f = 1'b0;
        step();
        chk("post_flush_instr", instr_d, 32'hA000_0012);
        chk("post_flush_pc", pc_f, 32'h4c);

        // live redirect on release beats pending target
        stall_f = 1'b1; redirect = 1'b1; redirect_pc = 32'h10;
        step();
        stall_f = 1'b0; redirect_pc = 32'h30;
        step();
        redirect = 1'b0;
        chk("live_beats_pend_pc", pc_f, 32'h30);
        step();
        chk("live_beats_pend_next", pc_f, 32'h34);
        chk("live_beats_pend_instr", instr_d, 32'hA000_000C);

        // reset during stall with pending redirect
        stall_f = 1'b1; redirect = 1'b1; redirect_pc = 32'h60;
        step();
        reset = 1'b1; redirect = 1'b0;
        step();
        chk("rst_mid_pc", pc_f, 32'h0);
        chk("rst_mid_valid", {31'b0, valid_d}, 32'd0);
        reset = 1'b0; stall_f = 1'b0;
        step();
        chk("rst_mid_boot_valid", {31'b0, valid_d}, 32'd0);
        step();
        chk("rst_mid_instr", instr_d, 32'd11);
        chk("rst_mid_pc_next", pc_f, 32'h4);

        // misaligned redirect faults
        redirect = 1'b1; redirect_pc = 32'h22;
        step();
        redirect = 1'b0;
        chk("mis_pc", pc_f, 32'h22);
        chk("mis_fault_pre", {31'b0, fetch_fault}, 32'd0);
        step();
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        chk("mis_valid", {31'b0, valid_d}, 32'd0);
        chk("mis_instr", instr_d, 32'h0);
        chk("mis_pc_frozen", pc_f, 32'h22);
        redirect = 1'b1; redirect_pc = 32'h0; stall_f = 1'b1;
        step();
        step();
        redirect = 1'b0; stall_f = 1'b0;
        chk("fault_ign_pc", pc_f, 32'h22);
        chk("fault_ign_fault", {31'b0, fetch_fault}, 32'd1);
        chk("fault_ign_valid", {31'b0, valid_d}, 32'd0);

        // out-of-range boundary: index 39 valid, index 40 faults
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_fault", {31'b0, fetch_fault}, 32'd0);
        step();
        redirect = 1'b1; redirect_pc = 32'h9C;
        step();
        redirect = 1'b0;
        chk("oor_pc39", pc_f, 32'h9C);
        step();
        chk("oor_last_instr", instr_d, 32'hA000_0027);
        chk("oor_last_valid", {31'b0, valid_d}, 32'd1);
        chk("oor_pc40", pc_f, 32'hA0);
        chk("oor_fault_pre", {31'b0, fetch_fault}, 32'd0);
        step();
        chk("oor_fault", {31'b0, fetch_fault}, 32'd1);
        chk("oor_valid", {31'b0, valid_d}, 32'd0);
        chk("oor_pc_frozen", pc_f, 32'hA0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
